// File: rtl/ex_stage_if.sv
// Decoded-operation bundles feeding the execute stage: one-hot ALU flags and memory-op flags.
interface alu_ops_if;
  logic add_op;
  logic sub_op;
  logic and_op;
  logic or_op;
  logic xor_op;
  logic sll_op;
  logic srl_op;
  logic sra_op;
  logic slt_op;

  modport src (output add_op, sub_op, and_op, or_op, xor_op, sll_op, srl_op, sra_op, slt_op);
  modport dst (input  add_op, sub_op, and_op, or_op, xor_op, sll_op, srl_op, sra_op, slt_op);
endinterface

interface io_ops_if;
  logic load_op;
  logic store_op;

  modport src (output load_op, store_op);
  modport dst (input  load_op, store_op);
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU / address generation, one-cycle registered output.
// Optional macro EX_FORWARD_EN enables MA/WB operand forwarding; without it ma_*/wb_* are ignored.
module ex_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  alu_ops_if.dst          alu_ops,
  io_ops_if.dst           io_ops,
  input  logic            clear,
  input  logic            stall,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] imm,
  input  logic            with_imm,
  input  logic [4:0]      ma_rd,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] ma_data,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_load,
  output logic            ex_store
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_r2;
  logic [XLEN-1:0] op_b;
  logic [5:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result;

`ifdef EX_FORWARD_EN
  // MA is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    op_a  = data1;
    op_r2 = data2;
    if (rs1 != '0 && rs1 == ma_rd)
      op_a = ma_data;
    else if (rs1 != '0 && rs1 == wb_rd)
      op_a = wb_data;
    if (rs2 != '0 && rs2 == ma_rd)
      op_r2 = ma_data;
    else if (rs2 != '0 && rs2 == wb_rd)
      op_r2 = wb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ma_rd, wb_rd, ma_data, wb_data, rs1, rs2};

  always_comb begin
    op_a  = data1;
    op_r2 = data2;
  end
`endif

  assign op_b  = with_imm ? imm : op_r2;
  assign shamt = op_b[5:0];

  // Priority chain: the first flag in add..slt order wins if several are set.
  always_comb begin
    alu_res = '0;
    if (alu_ops.add_op)
      alu_res = op_a + op_b;
    else if (alu_ops.sub_op)
      alu_res = op_a - op_b;
    else if (alu_ops.and_op)
      alu_res = op_a & op_b;
    else if (alu_ops.or_op)
      alu_res = op_a | op_b;
    else if (alu_ops.xor_op)
      alu_res = op_a ^ op_b;
    else if (alu_ops.sll_op)
      alu_res = op_a << shamt;
    else if (alu_ops.srl_op)
      alu_res = op_a >> shamt;
    else if (alu_ops.sra_op)
      alu_res = $signed(op_a) >>> shamt;
    else if (alu_ops.slt_op)
      alu_res[0] = ($signed(op_a) < $signed(op_b));
  end

  always_comb begin
    result = alu_res;
    if (io_ops.load_op || io_ops.store_op)
      result = op_a + imm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rd         <= '0;
      ex_result     <= '0;
      ex_store_data <= '0;
      ex_load       <= 1'b0;
      ex_store      <= 1'b0;
    end else if (clear) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rd         <= '0;
      ex_result     <= '0;
      ex_store_data <= '0;
      ex_load       <= 1'b0;
      ex_store      <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= 1'b1;
      ex_pc         <= pc;
      ex_rd         <= rd;
      ex_result     <= result;
      ex_store_data <= op_r2;
      ex_load       <= io_ops.load_op;
      ex_store      <= io_ops.store_op;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expectations adapt to whether EX_FORWARD_EN is defined.
module tb_ex_stage;
  localparam int unsigned XLEN = 64;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            clear;
  logic            stall;
  logic [XLEN-1:0] pc;
  logic [4:0]      rd, rs1, rs2, ma_rd, wb_rd;
  logic [XLEN-1:0] data1, data2, imm, ma_data, wb_data;
  logic            with_imm;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] ex_store_data;
  logic            ex_load;
  logic            ex_store;

  int total;
  int bad;

  alu_ops_if alu_i ();
  io_ops_if  io_i ();

  ex_stage #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_ops       (alu_i),
    .io_ops        (io_i),
    .clear         (clear),
    .stall         (stall),
    .pc            (pc),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .data1         (data1),
    .data2         (data2),
    .imm           (imm),
    .with_imm      (with_imm),
    .ma_rd         (ma_rd),
    .wb_rd         (wb_rd),
    .ma_data       (ma_data),
    .wb_data       (wb_data),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_rd         (ex_rd),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_load       (ex_load),
    .ex_store      (ex_store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ops bit order: add, sub, and, or, xor, sll, srl, sra, slt
  task automatic set_ops(input logic [8:0] ops, input logic ld, input logic st);
    alu_i.add_op = ops[0];
    alu_i.sub_op = ops[1];
    alu_i.and_op = ops[2];
    alu_i.or_op  = ops[3];
    alu_i.xor_op = ops[4];
    alu_i.sll_op = ops[5];
    alu_i.srl_op = ops[6];
    alu_i.sra_op = ops[7];
    alu_i.slt_op = ops[8];
    io_i.load_op  = ld;
    io_i.store_op = st;
  endtask

  task automatic idle_inputs();
    set_ops(9'b0, 1'b0, 1'b0);
    clear = 0; stall = 0; pc = '0; rd = '0; rs1 = '0; rs2 = '0;
    data1 = '0; data2 = '0; imm = '0; with_imm = 0;
    ma_rd = '0; wb_rd = '0; ma_data = '0; wb_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    set_ops(9'b1, 1'b1, 1'b1);
    pc = 64'h1234; rd = 5'd9; data1 = 64'h55;
    rst = 1'b1;
    step();
    step();
    total++;
    if ({ex_valid, ex_pc, ex_rd, ex_result, ex_store_data, ex_load, ex_store} !== '0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b pc=%h rd=%0d res=%h sd=%h ld=%b st=%b expected all 0",
               ex_valid, ex_pc, ex_rd, ex_result, ex_store_data, ex_load, ex_store);
    end
    #2 rst = 1'b0;
    idle_inputs();
  endtask

  task automatic load_fwd_vector();
    idle_inputs();
    pc = 64'h400; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd4;
    data1 = 64'd256; data2 = 64'd512; with_imm = 0;
    ma_rd = 5'd3; ma_data = 64'hDDAA; wb_rd = 5'd6; wb_data = 64'h7777;
  endtask

  task automatic test_forward();
    logic [XLEN-1:0] exp;
    load_fwd_vector();
    set_ops(9'b000000001, 1'b0, 1'b0);
    step();
    exp = FWD ? 64'hDFAA : 64'h300;
    total++;
    if (ex_result !== exp) begin bad++; $display("FAIL fwd_result: got %h expected %h", ex_result, exp); end
    total++;
    if ({ex_valid, ex_rd, ex_pc, ex_store_data} !== {1'b1, 5'd5, 64'h400, 64'd512}) begin
      bad++;
      $display("FAIL fwd_fields: got valid=%b rd=%0d pc=%h sd=%h expected valid=1 rd=5 pc=400 sd=200",
               ex_valid, ex_rd, ex_pc, ex_store_data);
    end
  endtask

  task automatic test_load_store();
    logic [XLEN-1:0] exp;
    load_fwd_vector();
    set_ops(9'b000000001, 1'b1, 1'b1);
    imm = 64'd1024;
    step();
    exp = FWD ? 64'hE1AA : 64'h500;
    total++;
    if (ex_result !== exp) begin bad++; $display("FAIL ls_addr: got %h expected %h", ex_result, exp); end
    total++;
    if ({ex_store_data, ex_load, ex_store, ex_rd} !== {64'd512, 1'b1, 1'b1, 5'd5}) begin
      bad++;
      $display("FAIL ls_fields: got sd=%h ld=%b st=%b rd=%0d expected sd=200 ld=1 st=1 rd=5",
               ex_store_data, ex_load, ex_store, ex_rd);
    end
  endtask

  task automatic test_priority();
    logic [XLEN-1:0] exp;
    idle_inputs();
    set_ops(9'b000000001, 1'b0, 1'b0);
    rs1 = 5'd3; data1 = 64'h100; ma_rd = 5'd3; wb_rd = 5'd3; ma_data = 64'h11; wb_data = 64'h22;
    step();
    exp = FWD ? 64'h11 : 64'h100;
    total++;
    if (ex_result !== exp) begin bad++; $display("FAIL prio_ma_over_wb: got %h expected %h", ex_result, exp); end

    ma_rd = 5'd7;
    step();
    exp = FWD ? 64'h22 : 64'h100;
    total++;
    if (ex_result !== exp) begin bad++; $display("FAIL prio_wb_only: got %h expected %h", ex_result, exp); end

    rs1 = 5'd0; ma_rd = 5'd0; ma_data = 64'h99; wb_rd = 5'd0; data1 = 64'h55;
    step();
    total++;
    if (ex_result !== 64'h55) begin bad++; $display("FAIL x0_no_fwd: got %h expected 55", ex_result); end

    rs2 = 5'd4; data2 = 64'hAB; wb_rd = 5'd4; wb_data = 64'h30;
    step();
    exp = FWD ? 64'h30 : 64'hAB;
    total++;
    if (ex_store_data !== exp) begin bad++; $display("FAIL rs2_fwd: got %h expected %h", ex_store_data, exp); end
    total++;
    if (ex_result !== 64'h55 + exp) begin bad++; $display("FAIL rs2_fwd_sum: got %h expected %h", ex_result, 64'h55 + exp); end
  endtask

  logic [8:0]      t_ops [14];
  logic [XLEN-1:0] t_a   [14];
  logic [XLEN-1:0] t_b   [14];
  logic            t_wi  [14];
  logic [XLEN-1:0] t_exp [14];

  task automatic test_alu();
    t_ops[0]  = 9'b000000010; t_a[0]  = 64'd10;   t_b[0]  = 64'd3;    t_wi[0]  = 0; t_exp[0]  = 64'd7;
    t_ops[1]  = 9'b000000010; t_a[1]  = 64'd0;    t_b[1]  = 64'd1;    t_wi[1]  = 0; t_exp[1]  = 64'hFFFF_FFFF_FFFF_FFFF;
    t_ops[2]  = 9'b000000100; t_a[2]  = 64'hF0F0; t_b[2]  = 64'hFF00; t_wi[2]  = 0; t_exp[2]  = 64'hF000;
    t_ops[3]  = 9'b000001000; t_a[3]  = 64'hF0F0; t_b[3]  = 64'hFF00; t_wi[3]  = 0; t_exp[3]  = 64'hFFF0;
    t_ops[4]  = 9'b000010000; t_a[4]  = 64'hF0F0; t_b[4]  = 64'hFF00; t_wi[4]  = 0; t_exp[4]  = 64'h0FF0;
    t_ops[5]  = 9'b000100000; t_a[5]  = 64'd1;    t_b[5]  = 64'd63;   t_wi[5]  = 1; t_exp[5]  = 64'h8000_0000_0000_0000;
    t_ops[6]  = 9'b001000000; t_a[6]  = 64'h8000_0000_0000_0000; t_b[6] = 64'd4; t_wi[6] = 1; t_exp[6] = 64'h0800_0000_0000_0000;
    t_ops[7]  = 9'b010000000; t_a[7]  = 64'h8000_0000_0000_0000; t_b[7] = 64'd4; t_wi[7] = 1; t_exp[7] = 64'hF800_0000_0000_0000;
    t_ops[8]  = 9'b000100000; t_a[8]  = 64'd3;    t_b[8]  = 64'd68;   t_wi[8]  = 1; t_exp[8]  = 64'h30;
    t_ops[9]  = 9'b100000000; t_a[9]  = 64'hFFFF_FFFF_FFFF_FFFF; t_b[9] = 64'd1; t_wi[9] = 0; t_exp[9] = 64'd1;
    t_ops[10] = 9'b100000000; t_a[10] = 64'd1;    t_b[10] = 64'hFFFF_FFFF_FFFF_FFFF; t_wi[10] = 0; t_exp[10] = 64'd0;
    t_ops[11] = 9'b000000000; t_a[11] = 64'd5;    t_b[11] = 64'd6;    t_wi[11] = 0; t_exp[11] = 64'd0;
    t_ops[12] = 9'b000010010; t_a[12] = 64'd9;    t_b[12] = 64'd3;    t_wi[12] = 0; t_exp[12] = 64'd6;
    t_ops[13] = 9'b100000001; t_a[13] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[13] = 64'd1; t_wi[13] = 0; t_exp[13] = 64'd0;
    idle_inputs();
    for (int i = 0; i < 14; i++) begin
      set_ops(t_ops[i], 1'b0, 1'b0);
      data1 = t_a[i];
      with_imm = t_wi[i];
      if (t_wi[i]) begin imm = t_b[i]; data2 = 64'hDEAD; end
      else begin imm = 64'hBEEF; data2 = t_b[i]; end
      pc = 64'h1000 + 64'(i * 4);
      step();
      total++;
      if (ex_result !== t_exp[i] || ex_valid !== 1'b1) begin
        bad++;
        $display("FAIL alu_vec%0d: got res=%h valid=%b expected res=%h valid=1", i, ex_result, ex_valid, t_exp[i]);
      end
    end
  endtask

  task automatic test_stall_clear();
    idle_inputs();
    set_ops(9'b000000001, 1'b0, 1'b1);
    pc = 64'h10; rd = 5'd7; data1 = 64'd1; data2 = 64'd2; imm = 64'd8;
    step();
    total++;
    if ({ex_valid, ex_pc, ex_rd, ex_result, ex_store} !== {1'b1, 64'h10, 5'd7, 64'd9, 1'b1}) begin
      bad++;
      $display("FAIL stall_capture: got valid=%b pc=%h rd=%0d res=%h st=%b expected 1 10 7 9 1",
               ex_valid, ex_pc, ex_rd, ex_result, ex_store);
    end
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      pc = 64'h20 + 64'(c); rd = 5'(c + 1); data1 = 64'(100 + c); set_ops(9'b000000010, 1'b1, 1'b0);
      step();
      total++;
      if ({ex_valid, ex_pc, ex_rd, ex_result, ex_store_data, ex_load, ex_store} !==
          {1'b1, 64'h10, 5'd7, 64'd9, 64'd2, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h rd=%0d res=%h sd=%h ld=%b st=%b expected 1 10 7 9 2 0 1",
                 c, ex_valid, ex_pc, ex_rd, ex_result, ex_store_data, ex_load, ex_store);
      end
    end
    clear = 1;
    step();
    total++;
    if ({ex_valid, ex_rd, ex_pc, ex_result, ex_store_data, ex_load, ex_store} !== '0) begin
      bad++;
      $display("FAIL stall_clear: got valid=%b rd=%0d pc=%h res=%h sd=%h ld=%b st=%b expected all 0",
               ex_valid, ex_rd, ex_pc, ex_result, ex_store_data, ex_load, ex_store);
    end
    clear = 0; stall = 0;
    step();
    total++;
    if ({ex_valid, ex_pc, ex_load} !== {1'b1, 64'h22, 1'b1}) begin
      bad++;
      $display("FAIL resume: got valid=%b pc=%h ld=%b expected 1 22 1", ex_valid, ex_pc, ex_load);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    set_ops(9'b000000001, 1'b1, 1'b0);
    pc = 64'h80; rd = 5'd12; data1 = 64'd40; data2 = 64'd2;
    step();
    stall = 1;
    step();
    total++;
    if ({ex_valid, ex_pc} !== {1'b1, 64'h80}) begin
      bad++;
      $display("FAIL pre_reset: got valid=%b pc=%h expected 1 80", ex_valid, ex_pc);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ex_valid, ex_pc, ex_rd, ex_result, ex_store_data, ex_load, ex_store} !== '0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b pc=%h rd=%0d res=%h sd=%h ld=%b st=%b expected all 0",
               ex_valid, ex_pc, ex_rd, ex_result, ex_store_data, ex_load, ex_store);
    end
    step();
    #2 rst = 1'b0;
    step();
    total++;
    if ({ex_valid, ex_pc, ex_result} !== '0) begin
      bad++;
      $display("FAIL reset_discard: got valid=%b pc=%h res=%h expected all 0", ex_valid, ex_pc, ex_result);
    end
    stall = 0;
    step();
    total++;
    if ({ex_valid, ex_pc, ex_result, ex_load} !== {1'b1, 64'h80, 64'd40, 1'b1}) begin
      bad++;
      $display("FAIL post_reset: got valid=%b pc=%h res=%h ld=%b expected 1 80 28 1",
               ex_valid, ex_pc, ex_result, ex_load);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_forward();
    test_load_store();
    test_priority();
    test_alu();
    test_stall_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port alu_ops  interface (dst modport)  9 one-hot flags: add, sub, and, or, xor, sll, srl, sra, slt.
REQ-005 SHALL have port io_ops  interface (dst modport)  2 flags: load_op, store_op.
REQ-006 SHALL have port clear  input  1  flush; the next registered output is a bubble.
REQ-007 SHALL have port stall  input  1  hold all output registers.
REQ-008 SHALL have ports pc  input  XLEN; rd/rs1/rs2  input  5; data1/data2/imm  input  XLEN; with_imm  input  1.
REQ-009 SHALL have ports ma_rd/wb_rd  input  5; ma_data/wb_data  input  XLEN; these are the forwarding sources.
REQ-010 SHALL have registered outputs: ex_valid 1, ex_pc XLEN, ex_rd 5, ex_result XLEN, ex_store_data XLEN, ex_load 1, ex_store 1.

Function
REQ-011 SHALL resolve operand A as follows, in priority order:
- ma_data if rs1!=0 and rs1==ma_rd;
- otherwise wb_data if rs1!=0 and rs1==wb_rd;
- otherwise data1.
REQ-012 SHALL resolve forwarded operand R2 from rs2/data2 with the same rule as REQ-011; register x0 is never forwarded.
REQ-013 SHALL use operand B = imm when with_imm=1, else R2.
REQ-014 SHALL compute the ALU result with these rules:
- add/sub/and/or/xor: modulo 2^XLEN;
- sll/srl/sra: shift amount B[5:0];
- sra: sign-extending;
- slt: signed compare, result 1 or 0, zero-extended.
REQ-015 SHALL, when several alu_ops flags are set, apply the first in REQ-004 order; with no flag set, the ALU result SHALL be 0.
REQ-016 SHALL, when load_op or store_op is set, set ex_result = A + imm (address), overriding the ALU result.
REQ-017 SHALL set ex_store_data = R2 on every captured instruction.
REQ-018 SHALL have latency of exactly one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-019 SHALL, when stall=1 and clear=0, hold every output register unchanged.
REQ-020 SHALL, when clear=1, load a bubble regardless of stall:
- ex_valid=0, ex_rd=0, ex_load=0, ex_store=0;
- ex_pc, ex_result, ex_store_data = 0.
REQ-021 SHALL, when stall=0 and clear=0, capture the new instruction with ex_valid=1.
REQ-022 SHALL, when load_op and store_op are both set, drive both ex_load=1 and ex_store=1 unchanged; the downstream stage arbitrates.
REQ-023 SHALL, on a store, drive ex_rd with the rd input without masking.

Reset
REQ-024 SHALL, on rst=1, immediately and without waiting for clk, drive every output register to 0, including ex_valid=0.
REQ-025 SHALL, on reset asserted mid-operation, discard any held (stalled) instruction; the first edge after rst deasserts SHALL follow REQ-019 to REQ-021.

Configuration
REQ-026 SHALL provide macro EX_FORWARD_EN:
- defined: operand selection SHALL follow REQ-011 and REQ-012;
- undefined: A=data1 and R2=data2 always, and ma_*/wb_* are ignored.

Verification
REQ-027 SHALL cover forwarding with EX_FORWARD_EN defined: pc=0x400, rd=5, rs1=3, rs2=4, data1=256, data2=512, with_imm=0, ma_rd=3, ma_data=0xDDAA, wb_rd=6, add -> ex_result=0xDFAA, ex_rd=5, ex_pc=0x400, ex_valid=1 one cycle later.
REQ-028 SHALL cover forwarding disabled: same stimulus with EX_FORWARD_EN undefined -> ex_result=768 (0x300).
REQ-029 SHALL cover load/store with forwarding: same stimulus plus load_op=1, store_op=1, imm=1024 -> ex_result=0xE1AA, ex_store_data=512, ex_load=1, ex_store=1.
REQ-030 SHALL cover priority and x0 rules:
- ma_rd=wb_rd=3, ma_data=0x11, wb_data=0x22 -> A=0x11;
- rs1=0 with ma_rd=0, ma_data=0x99 -> A=data1.
REQ-031 SHALL cover stall then clear: stall=1 for 3 cycles while inputs change -> outputs constant; then stall=1 and clear=1 together -> ex_valid=0, ex_rd=0 next cycle.
REQ-032 SHALL cover ALU edge cases: sra, data1=0x8000_0000_0000_0000, imm=4, with_imm=1 -> 0xF800_0000_0000_0000; slt, data1=-1, data2=1 -> 1; rst pulse between clk edges -> all outputs 0 immediately.
